// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display path: active-low
// segment patterns ({g,f,e,d,c,b,a}), the all-off anode word and scan slot encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'hF;

  localparam int IDX_W = 2;

  // Slot order follows the scan: units first, thousands last.
  typedef enum logic [IDX_W-1:0] {
    SLOT_UNITS     = 2'd0,
    SLOT_TENS      = 2'd1,
    SLOT_HUNDREDS  = 2'd2,
    SLOT_THOUSANDS = 2'd3
  } slot_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// 4-digit multiplexed display scanner with per-frame snapshot and inter-digit blanking.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits of the snapshot.
module bcd_display_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Qdata3,
  input  logic [3:0] Qdata2,
  input  logic [3:0] Qdata1,
  input  logic [3:0] Qdata0,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int PW = 20;

  logic [PW-1:0]      presc_q;
  slot_e              idx_q;
  logic [IDX_W-1:0]   idx_inc;
  logic [3:0][3:0]    snap_q;
  logic [6:0]         seg_q;
  logic [3:0]         an_q;
  logic               frame_done_q;

  logic               tick;
  logic               frame_end;
  logic [3:0]         digit;
  logic [6:0]         dec_seg;
  logic [3:0]         lz_blank;
  logic               slot_on;
  logic [6:0]         seg_d;
  logic [3:0]         an_d;

  assign tick      = (presc_q == PW'(SCAN_DIV - 1));
  assign frame_end = tick && (idx_q == SLOT_THOUSANDS);
  assign idx_inc   = idx_q + 1'b1;
  assign digit     = snap_q[idx_q];

  bcd_to_seg7 u_dec (
    .bcd_i (digit),
    .seg_o (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is dark only if it and every digit above it are zero; units always shows.
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (snap_q[3] == 4'd0);
    lz_blank[2] = lz_blank[3] && (snap_q[2] == 4'd0);
    lz_blank[1] = lz_blank[2] && (snap_q[1] == 4'd0);
  end
`else
  assign lz_blank = 4'b0000;
`endif

  assign slot_on = (presc_q >= PW'(BLANK_CYC)) && !lz_blank[idx_q];
  assign an_d    = slot_on ? ~(4'b0001 << idx_q) : AN_OFF;
  assign seg_d   = slot_on ? dec_seg : SEG_OFF;

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q      <= '0;
      idx_q        <= SLOT_UNITS;
      snap_q       <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= tick ? '0 : presc_q + 1'b1;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_end;
      if (tick) begin
        idx_q <= slot_e'(idx_inc);
      end
      // Latch a whole frame at once so a count change never shows half-applied.
      if (frame_end) begin
        snap_q <= {Qdata3, Qdata2, Qdata1, Qdata0};
      end
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan (SCAN_DIV=8, BLANK_CYC=2); honours LEADING_ZERO_BLANK_EN.
module tb_bcd_display_scan;

  localparam int SD = 8;
  localparam int BC = 2;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] q3 = 4'd0, q2 = 4'd0, q1 = 4'd0, q0 = 4'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       fd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  obs_t exp_q[$];

  bcd_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .Qdata3     (q3),
    .Qdata2     (q2),
    .Qdata1     (q1),
    .Qdata0     (q0),
    .seg        (seg),
    .an         (an),
    .frame_done (fd)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Reference model: every clock edge pushes the output the DUT should register.
  int         m_presc = 0;
  int         m_idx   = 0;
  logic [3:0] m_snap [4] = '{default: 4'd0};

  always @(posedge clk) begin : model
    obs_t       e;
    logic [3:0] blank;
    if (!rst) begin
      e = '{seg: 7'h7F, an: 4'hF, fd: 1'b0};
      m_presc <= 0;
      m_idx   <= 0;
      for (int i = 0; i < 4; i++) m_snap[i] <= 4'd0;
    end else begin
      blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
      blank[3] = (m_snap[3] == 0);
      blank[2] = blank[3] && (m_snap[2] == 0);
      blank[1] = blank[2] && (m_snap[1] == 0);
`endif
      e.fd = (m_presc == SD - 1) && (m_idx == 3);
      if (m_presc >= BC && !blank[m_idx]) begin
        e.an  = ~(4'b0001 << m_idx);
        e.seg = ref_dec(m_snap[m_idx]);
      end else begin
        e.an  = 4'hF;
        e.seg = 7'h7F;
      end
      if (m_presc == SD - 1) begin
        m_presc <= 0;
        m_idx   <= (m_idx + 1) % 4;
        if (m_idx == 3) begin
          m_snap[3] <= q3; m_snap[2] <= q2; m_snap[1] <= q1; m_snap[0] <= q0;
        end
      end else begin
        m_presc <= m_presc + 1;
      end
    end
    exp_q.push_back(e);
  end

  // Advance one cycle: sample the DUT on the falling edge and pop the model's entry.
  task automatic step(output obs_t e, output obs_t o);
    @(negedge clk);
    cyc++;
    o = '{seg: seg, an: an, fd: fd};
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
  endtask

  // Expected output k cycles into a frame that starts right after a frame_done.
  function automatic obs_t frame_exp(input int k, input logic [3:0][6:0] s, input logic [3:0] blank);
    obs_t r;
    int   slot = k / SD;
    int   pos  = k % SD;
    r.fd = (k == 4 * SD - 1);
    if (pos < BC || blank[slot]) begin
      r.an = 4'hF; r.seg = 7'h7F;
    end else begin
      r.an = ~(4'b0001 << slot); r.seg = s[slot];
    end
    return r;
  endfunction

  function automatic logic [3:0] zero_blank();
`ifdef LEADING_ZERO_BLANK_EN
    return 4'b1110;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic test_reset();
    obs_t e, o, f;
    rst = 1'b0; q3 = 4'd9; q2 = 4'd6; q1 = 4'd7; q0 = 4'd5;
    for (int i = 0; i < 3; i++) begin
      step(e, o);
      n_checks++;
      if (o !== '{seg: 7'h7F, an: 4'hF, fd: 1'b0}) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d: got seg=%h an=%h fd=%b, want seg=7f an=f fd=0", cyc, o.seg, o.an, o.fd);
      end
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_model cyc=%0d: got %h/%h/%b, want %h/%h/%b", cyc, o.seg, o.an, o.fd, e.seg, e.an, e.fd);
      end
    end
    rst = 1'b1;
    for (int k = 0; k < 4 * SD; k++) begin
      step(e, o);
      f = frame_exp(k, {4{7'h40}}, zero_blank());
      n_checks++;
      if (o !== f || o !== e) begin
        n_fail++;
        $display("FAIL reset_frame k=%0d: got %h/%h/%b, want %h/%h/%b", k, o.seg, o.an, o.fd, f.seg, f.an, f.fd);
      end
      $display("reset_frame k=%0d seg=%h an=%h fd=%b", k, o.seg, o.an, o.fd);
    end
  endtask

  task automatic test_scan();
    obs_t e, o, f;
    bit   seen = 0;
    for (int i = 0; i < 5 * SD && !seen; i++) begin
      step(e, o);
      seen = o.fd;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL scan_wait cyc=%0d: got %h/%h/%b, want %h/%h/%b", cyc, o.seg, o.an, o.fd, e.seg, e.an, e.fd);
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL scan_frame_done_timeout: got no pulse, want one within %0d cycles", 5 * SD);
    end
    for (int k = 0; k < 4 * SD; k++) begin
      step(e, o);
      f = frame_exp(k, {7'h10, 7'h02, 7'h78, 7'h12}, 4'b0000);
      n_checks++;
      if (o !== f || o !== e) begin
        n_fail++;
        $display("FAIL scan_9675 k=%0d: got %h/%h/%b, want %h/%h/%b", k, o.seg, o.an, o.fd, f.seg, f.an, f.fd);
      end
      $display("scan k=%0d seg=%h an=%h fd=%b", k, o.seg, o.an, o.fd);
    end
  endtask

  task automatic test_tearing();
    obs_t e, o, f;
    for (int k = 0; k < 4 * SD; k++) begin
      if (k == SD + 2) begin
        q0 = 4'd3;
        q3 = 4'd8;
      end
      step(e, o);
      f = frame_exp(k, {7'h10, 7'h02, 7'h78, 7'h12}, 4'b0000);
      n_checks++;
      if (o !== f || o !== e) begin
        n_fail++;
        $display("FAIL tear_hold k=%0d: got %h/%h/%b, want %h/%h/%b", k, o.seg, o.an, o.fd, f.seg, f.an, f.fd);
      end
    end
    for (int k = 0; k < 4 * SD; k++) begin
      step(e, o);
      f = frame_exp(k, {7'h00, 7'h02, 7'h78, 7'h30}, 4'b0000);
      n_checks++;
      if (o !== f || o !== e) begin
        n_fail++;
        $display("FAIL tear_next k=%0d: got %h/%h/%b, want %h/%h/%b", k, o.seg, o.an, o.fd, f.seg, f.an, f.fd);
      end
      $display("tear k=%0d seg=%h an=%h fd=%b", k, o.seg, o.an, o.fd);
    end
  endtask

  task automatic test_invalid_bcd();
    obs_t e, o, f;
    q2 = 4'hC;
    for (int k = 0; k < 4 * SD; k++) begin
      step(e, o);
      f = frame_exp(k, {7'h00, 7'h02, 7'h78, 7'h30}, 4'b0000);
      n_checks++;
      if (o !== f || o !== e) begin
        n_fail++;
        $display("FAIL invalid_old k=%0d: got %h/%h/%b, want %h/%h/%b", k, o.seg, o.an, o.fd, f.seg, f.an, f.fd);
      end
    end
    for (int k = 0; k < 4 * SD; k++) begin
      step(e, o);
      f = frame_exp(k, {7'h00, 7'h3F, 7'h78, 7'h30}, 4'b0000);
      n_checks++;
      if (o !== f || o !== e) begin
        n_fail++;
        $display("FAIL invalid_dash k=%0d: got %h/%h/%b, want %h/%h/%b", k, o.seg, o.an, o.fd, f.seg, f.an, f.fd);
      end
      $display("invalid k=%0d seg=%h an=%h fd=%b", k, o.seg, o.an, o.fd);
    end
  endtask

  task automatic test_leading_zero();
    obs_t       e, o, f;
    logic [3:0] bl;
`ifdef LEADING_ZERO_BLANK_EN
    bl = 4'b1100;
`else
    bl = 4'b0000;
`endif
    q3 = 4'd0; q2 = 4'd0; q1 = 4'd4; q0 = 4'd5;
    for (int k = 0; k < 4 * SD; k++) begin
      step(e, o);
      f = frame_exp(k, {7'h00, 7'h3F, 7'h78, 7'h30}, 4'b0000);
      n_checks++;
      if (o !== f || o !== e) begin
        n_fail++;
        $display("FAIL lzb_old k=%0d: got %h/%h/%b, want %h/%h/%b", k, o.seg, o.an, o.fd, f.seg, f.an, f.fd);
      end
    end
    for (int k = 0; k < 4 * SD; k++) begin
      step(e, o);
      f = frame_exp(k, {7'h40, 7'h40, 7'h19, 7'h12}, bl);
      n_checks++;
      if (o !== f || o !== e) begin
        n_fail++;
        $display("FAIL lzb_0045 k=%0d: got %h/%h/%b, want %h/%h/%b", k, o.seg, o.an, o.fd, f.seg, f.an, f.fd);
      end
      $display("lzb k=%0d seg=%h an=%h fd=%b", k, o.seg, o.an, o.fd);
    end
  endtask

  task automatic test_midslot_reset();
    obs_t e, o, f;
    for (int k = 0; k < SD + 4; k++) begin
      step(e, o);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midrst_pre k=%0d: got %h/%h/%b, want %h/%h/%b", k, o.seg, o.an, o.fd, e.seg, e.an, e.fd);
      end
    end
    rst = 1'b0;
    step(e, o);
    n_checks++;
    if (o !== '{seg: 7'h7F, an: 4'hF, fd: 1'b0} || o !== e) begin
      n_fail++;
      $display("FAIL midrst_apply: got %h/%h/%b, want 7f/f/0", o.seg, o.an, o.fd);
    end
    rst = 1'b1;
    for (int k = 0; k < 4 * SD; k++) begin
      step(e, o);
      f = frame_exp(k, {4{7'h40}}, zero_blank());
      n_checks++;
      if (o !== f || o !== e) begin
        n_fail++;
        $display("FAIL midrst_frame k=%0d: got %h/%h/%b, want %h/%h/%b", k, o.seg, o.an, o.fd, f.seg, f.an, f.fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tearing();
    test_invalid_bcd();
    test_leading_zero();
    test_midslot_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Reads the four BCD digit values (Qdata3..Qdata0, thousands..units) produced by the 0–9675 counter chain.
- Drives a 4-digit common-anode multiplexed 7-segment display.
- Built from a prescaler, a digit-scan counter, a frame snapshot register to prevent tearing, and an inter-digit blanking window to suppress ghosting.
- Pure consumer of counter state; it never drives the enables or resets of the counter chain.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (1 kHz slot rate at 50 MHz); legal range 2..2^20-1.
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off; must be < SCAN_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- Qdata3  input  4  thousands digit, BCD.
- Qdata2  input  4  hundreds digit, BCD.
- Qdata1  input  4  tens digit, BCD.
- Qdata0  input  4  units digit, BCD.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  4  digit anodes, an[3]=thousands, active-low.
- frame_done  output  1  one-cycle pulse when slot 3 ends (full frame shown).

Behaviour:
- Reset (rst=0 at clk edge):
  - presc=0, idx=0, snap0..3=0.
  - seg=7'h7F, an=4'hF, frame_done=0.
  - The reset takes effect on the next edge regardless of state, including mid-slot.
- Prescaler:
  - presc counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (presc==SCAN_DIV-1).
- Scan index:
  - On tick, idx advances 0→1→2→3→0.
  - Slot order is units, tens, hundreds, thousands.
- Snapshot:
  - On tick with idx==3, snap3..0 <= Qdata3..0.
  - The new frame is displayed from the next slot 0 onward.
  - Snapshot latency is at most 4*SCAN_DIV cycles.
  - Qdata changes within a frame are never shown mid-frame.
- Registered outputs, one cycle after presc/idx:
  - an = ~(4'b0001<<idx) when presc >= BLANK_CYC, else 4'hF.
  - seg = decode(snap[idx]) when an is active, else 7'h7F.
- Decode (active-low), hex values:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any value 10..15 is invalid BCD and displays dash 7'h3F (segment g only).
- frame_done:
  - Asserted for exactly one cycle, on the cycle after tick with idx==3.
  - This is the same edge on which the snapshot is updated.
- Boundary conditions:
  - Qdata changing on the same edge as the snapshot: the pre-edge value is captured.
  - Invalid BCD: dash only; never an X/undefined segment pattern.
  - Counter chain reaching 9675 and clearing: no special handling; the display shows whichever value was snapshotted.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Snapshot digits that are 0 and have only zero digits above them are blanked.
  - Blanked digits drive seg=7'h7F and an=4'hF for that slot.
  - Units digit is never blanked, so value 0000 shows "   0" and 0045 shows "  45".
  - The blank mask is computed from the snapshot, not live Qdata.
- Undefined: all four digits are always shown; 0045 shows "0045".

Decomposition:
- Package seg7_pkg holds:
  - Segment pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF).
  - AN_OFF.
  - Digit index width constant (2).
- Sub-module bcd_to_seg7: purely combinational 4-bit→7-bit decoder, instantiated once on the muxed snapshot digit.

Test Plan:
- Bench configuration for all scenarios: SCAN_DIV=8, BLANK_CYC=2.
- Reset: hold rst=0 for 3 cycles with Qdata=9,6,7,5 → seg=7F, an=F, frame_done=0 throughout. After release, slot 0 shows dash-free 0 (snap=0), an=E from cycle 3 of slot.
- Snapshot/scan: drive Qdata=9,6,7,5 before the first frame wrap →
  - frame_done pulses once every 32 cycles.
  - The next frame shows slot 0: an=E, seg=12; slot 1: an=D, seg=78; slot 2: an=B, seg=02; slot 3: an=7, seg=10.
- Tearing: change Qdata0 from 5 to 3 mid-frame at slot 1 → units keeps showing 12 until after the next frame_done, then shows 30.
- Blanking window: in every slot, an=F and seg=7F for exactly 2 cycles before the anode asserts.
- Invalid BCD: Qdata2=4'hC → the hundreds slot shows seg=3F while the other digits remain correct.
- With LEADING_ZERO_BLANK_EN, Qdata=0,0,4,5 → slots 2 and 3 have an=F; slot 0 seg=12, slot 1 seg=19. Without the macro, slots 2 and 3 show seg=40.
